dram_target: RTL and testbench
==============================

DRAM_TARGET -- requirements
Module: dram_target

Interface
REQ-001 Parameter AW, default 10; number of internal word-address bits; the array holds 2**AW x 16 words.
REQ-002 Parameter SYNC, default 2; synchronizer flop stages on every DRAM-side input, range 2-3.
REQ-003 clk  in  1  sole clock; every flop is clocked on its rising edge.
REQ-004 reset  in  1  synchronous reset, active-high.
REQ-005 ma  in  10  multiplexed address: row on the RAS_N fall, column (bits 7:0) on the CAS_N fall.
REQ-006 ras_n, cas_n  in  1 each  row and column strobes, active-low, asynchronous to clk.
REQ-007 uwe_n, lwe_n  in  1 each  upper-byte and lower-byte write enables, active-low.
REQ-008 oe_n  in  1  output enable, active-low.
REQ-009 dq_in  in  16  write data from the bus.
REQ-010 dq_out  out  16  read data to the bus.
REQ-011 dq_oe  out  1  enables the external tristate driver for dq_out.
REQ-012 refresh_count  out  16  count of completed refresh cycles.
REQ-013 row_active  out  1  high while a row is open.

Function
REQ-014 All DRAM-side inputs (ma, strobes, enables, dq_in) SHALL pass through SYNC flops.
REQ-015 All decisions SHALL use the synchronized samples.
REQ-016 Edges SHALL be detected against a one-cycle-delayed copy of each synchronized sample.
REQ-017 Word address SHALL be the low AW bits of {row[9:0], col[7:0]}.
REQ-018 FSM states SHALL be IDLE, ROW, COL_RD, COL_WR and CBR.
REQ-019 IDLE -> ROW on a RAS fall with CAS high: latch row from ma and set row_active.
REQ-020 IDLE -> CBR on a RAS fall with CAS already low.
REQ-021 ROW -> COL_WR on a CAS fall with uwe_n or lwe_n low (early write).
- Write dq_in to the byte lanes whose enable is low, in the same cycle.
REQ-022 ROW -> COL_RD on a CAS fall with both enables high.
- Read the array; dq_out is valid on the next cycle.
REQ-023 In COL_RD, dq_oe SHALL be registered.
- It is asserted one cycle after cas_n and oe_n are both low and synchronized.
- It is deasserted one cycle after either one rises.
REQ-024 In COL_RD, a falling edge of uwe_n or lwe_n (read-modify-write) SHALL do all of the following:
- Write dq_in to the enabled lanes.
- Drop dq_oe on the next cycle.
- Move to COL_WR.
REQ-025 COL_RD or COL_WR -> ROW on a CAS rise with RAS low (page mode).
- A new CAS fall repeats REQ-021 and REQ-022 with the same row.
REQ-026 A RAS rise SHALL return the FSM to IDLE from any state and clear row_active and dq_oe.
- It increments refresh_count when leaving ROW with no CAS cycle (RAS-only refresh).
- It increments refresh_count when leaving CBR.
REQ-027 refresh_count SHALL wrap from 0xFFFF to 0x0000.
REQ-028 A RAS rise and a CAS edge detected in the same cycle: the RAS rise wins and the CAS edge is ignored.
REQ-029 A CAS fall while in IDLE with RAS high SHALL have no effect.
REQ-030 A write enable edge in ROW or CBR SHALL have no effect.
REQ-031 dq_oe SHALL never be high in COL_WR, even if oe_n is low.
REQ-032 The array SHALL be written only in COL_WR entry cycles and RMW cycles.
- Each such event is exactly one write.

Reset
REQ-033 In every cycle with reset high:
- state = IDLE
- dq_oe = 0
- dq_out = 0x0000
- row_active = 0
- refresh_count = 0
- synchronizer and edge flops are set to the inactive (high) level
REQ-034 Array contents SHALL NOT be reset; reads of never-written words return unknown.
REQ-035 Reset mid-cycle: no write completes in the reset cycle, and dq_oe is 0 at the first edge.
REQ-036 After reset, the FSM SHALL wait for a RAS fall before it starts a new access.

Verification
REQ-037 Early write at address 255 with 0x5555 (both enables low), then a read of 255 with oe_n low -> dq_out = 0x5555, dq_oe high while CAS is low.
REQ-038 Early write at 256 with 0x6666, then read 256 -> 0x6666, and 255 still reads 0x5555.
REQ-039 Upper-byte write to 255 with 0xAB00 (uwe_n low, lwe_n high), then read 255 -> 0xAB55.
REQ-040 RMW at 256: read phase returns 0x6666, lwe_n/uwe_n fall with 0x1234 -> dq_oe drops; a later read of 256 returns 0x1234.
REQ-041 Three RAS-only refreshes, then one CBR refresh -> refresh_count = 4, array unchanged.
REQ-042 Reset asserted during a read with oe_n low -> dq_oe = 0 at the next edge; a following read of 256 still returns 0x1234.

Source files
------------

// File: rtl/dram_target.sv
// Asynchronous DRAM-protocol target: synchronizes RAS/CAS-style strobes into clk and
// serves early write, read, read-modify-write, page mode and RAS-only / CBR refresh.
module dram_target #(
  parameter int AW   = 10,
  parameter int SYNC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  ma,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        uwe_n,
  input  logic        lwe_n,
  input  logic        oe_n,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [15:0] refresh_count,
  output logic        row_active,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROW    = 3'd1,
    COL_RD = 3'd2,
    COL_WR = 3'd3,
    CBR    = 3'd4
  } state_t;

  localparam int IW = 31;

  state_t                  state;
  logic [IW-1:0]           raw;
  logic [SYNC-1:0][IW-1:0] sync_q;
  logic [IW-1:0]           s;
  logic [3:0]              prev_q;
  logic                    s_ras, s_cas, s_uwe, s_lwe, s_oe;
  logic [9:0]              s_ma;
  logic [15:0]             s_dq;
  logic                    ras_fall, ras_rise, cas_fall, cas_rise, we_fall;
  logic [9:0]              row_q;
  logic [7:0]              col_q;
  logic                    cas_seen;
  logic [15:0]             mem [2**AW];
  logic                    mem_we, lane_hi, lane_lo;
  logic [AW-1:0]           mem_addr, new_addr;

  assign raw = {ras_n, cas_n, uwe_n, lwe_n, oe_n, ma, dq_in};
  assign s   = sync_q[SYNC-1];
  assign s_ras = s[30];
  assign s_cas = s[29];
  assign s_uwe = s[28];
  assign s_lwe = s[27];
  assign s_oe  = s[26];
  assign s_ma  = s[25:16];
  assign s_dq  = s[15:0];

  // Edges compare the synchronized sample against its one-cycle-old copy.
  assign ras_fall = prev_q[3] & ~s_ras;
  assign ras_rise = ~prev_q[3] & s_ras;
  assign cas_fall = prev_q[2] & ~s_cas;
  assign cas_rise = ~prev_q[2] & s_cas;
  assign we_fall  = (prev_q[1] & ~s_uwe) | (prev_q[0] & ~s_lwe);

  assign new_addr  = AW'({row_q, s_ma[7:0]});
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], raw};
      prev_q <= {s_ras, s_cas, s_uwe, s_lwe};
    end
  end

  // A RAS rise takes priority, so no write is issued in that cycle.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = AW'({row_q, col_q});
    lane_hi  = ~s_uwe;
    lane_lo  = ~s_lwe;
    if (!reset && !ras_rise) begin
      if (state == ROW && cas_fall && (~s_uwe | ~s_lwe)) begin
        mem_we   = 1'b1;
        mem_addr = new_addr;
      end else if (state == COL_RD && !cas_rise && we_fall) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (lane_hi) mem[mem_addr][15:8] <= s_dq[15:8];
      if (lane_lo) mem[mem_addr][7:0]  <= s_dq[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dq_oe         <= 1'b0;
      dq_out        <= 16'h0000;
      row_active    <= 1'b0;
      refresh_count <= 16'h0000;
      row_q         <= '0;
      col_q         <= '0;
      cas_seen      <= 1'b0;
    end else if (ras_rise) begin
      if ((state == ROW && !cas_seen) || state == CBR)
        refresh_count <= refresh_count + 16'd1;
      state      <= IDLE;
      row_active <= 1'b0;
      dq_oe      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ras_fall) begin
            if (s_cas) begin
              state      <= ROW;
              row_q      <= s_ma;
              row_active <= 1'b1;
              cas_seen   <= 1'b0;
            end else begin
              state <= CBR;
            end
          end
        end
        ROW: begin
          if (cas_fall) begin
            cas_seen <= 1'b1;
            col_q    <= s_ma[7:0];
            if (~s_uwe | ~s_lwe) begin
              state <= COL_WR;
            end else begin
              state  <= COL_RD;
              dq_out <= mem[new_addr];
              dq_oe  <= ~s_oe;
            end
          end
        end
        COL_RD: begin
          if (cas_rise) begin
            state <= ROW;
            dq_oe <= 1'b0;
          end else if (we_fall) begin
            state <= COL_WR;
            dq_oe <= 1'b0;
          end else begin
            dq_oe <= ~s_cas & ~s_oe;
          end
        end
        COL_WR: begin
          dq_oe <= 1'b0;
          if (cas_rise) state <= ROW;
        end
        CBR: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_target.sv
// Directed bench for dram_target: writes, reads, byte writes, RMW, refresh and reset
// recovery, each checked against hand-computed values.
module tb_dram_target;

  localparam logic [2:0] S_IDLE = 3'd0, S_ROW = 3'd1, S_COL_RD = 3'd2,
                         S_COL_WR = 3'd3, S_CBR = 3'd4;
  localparam int SETTLE = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ma;
  logic        ras_n, cas_n, uwe_n, lwe_n, oe_n;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [15:0] refresh_count;
  logic        row_active;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  dram_target #(.AW(10), .SYNC(2)) dut (
    .clk(clk), .reset(reset), .ma(ma), .ras_n(ras_n), .cas_n(cas_n),
    .uwe_n(uwe_n), .lwe_n(lwe_n), .oe_n(oe_n), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .refresh_count(refresh_count),
    .row_active(row_active), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dram_write(input logic [17:0] addr, input logic [15:0] data,
                            input logic u_n, input logic l_n);
    ma = addr[17:8]; ras_n = 1'b0;
    settle(SETTLE);
    chk("wr_row_active", {31'd0, row_active}, 32'd1);
    ma = {2'b00, addr[7:0]}; dq_in = data; uwe_n = u_n; lwe_n = l_n; oe_n = 1'b0;
    cas_n = 1'b0;
    settle(SETTLE);
    chk("wr_state", {29'd0, state_dbg}, {29'd0, S_COL_WR});
    chk("wr_dq_oe_low", {31'd0, dq_oe}, 32'd0);
    cas_n = 1'b1;
    settle(SETTLE);
    ras_n = 1'b1; uwe_n = 1'b1; lwe_n = 1'b1; oe_n = 1'b1;
    settle(SETTLE);
  endtask

  task automatic dram_read(input logic [17:0] addr, input logic [15:0] exp);
    ma = addr[17:8]; ras_n = 1'b0;
    settle(SETTLE);
    ma = {2'b00, addr[7:0]}; oe_n = 1'b0; cas_n = 1'b0;
    settle(SETTLE);
    chk("rd_state", {29'd0, state_dbg}, {29'd0, S_COL_RD});
    chk("rd_data", {16'd0, dq_out}, {16'd0, exp});
    chk("rd_dq_oe_high", {31'd0, dq_oe}, 32'd1);
    cas_n = 1'b1;
    settle(SETTLE);
    chk("rd_dq_oe_drop", {31'd0, dq_oe}, 32'd0);
    ras_n = 1'b1; oe_n = 1'b1;
    settle(SETTLE);
  endtask

  task automatic ras_only(input logic [9:0] row);
    ma = row; ras_n = 1'b0;
    settle(SETTLE);
    chk("ror_state", {29'd0, state_dbg}, {29'd0, S_ROW});
    ras_n = 1'b1;
    settle(SETTLE);
  endtask

  initial begin
    reset = 1'b1; ma = '0; ras_n = 1'b1; cas_n = 1'b1; uwe_n = 1'b1;
    lwe_n = 1'b1; oe_n = 1'b1; dq_in = '0;
    settle(4);
    chk("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    chk("rst_dq_out", {16'd0, dq_out}, 32'd0);
    chk("rst_row_active", {31'd0, row_active}, 32'd0);
    chk("rst_refresh", {16'd0, refresh_count}, 32'd0);
    reset = 1'b0;
    settle(4);

    // Early writes and reads at the row boundary.
    dram_write(18'd255, 16'h5555, 1'b0, 1'b0);
    dram_read(18'd255, 16'h5555);
    dram_write(18'd256, 16'h6666, 1'b0, 1'b0);
    dram_read(18'd256, 16'h6666);
    dram_read(18'd255, 16'h5555);

    // Upper-byte-only write.
    dram_write(18'd255, 16'hAB00, 1'b0, 1'b1);
    dram_read(18'd255, 16'hAB55);
    chk("refresh_after_access", {16'd0, refresh_count}, 32'd0);

    // Three RAS-only refreshes then a CBR refresh.
    ras_only(10'd0);
    ras_only(10'd1);
    ras_only(10'd3);
    chk("refresh_ror3", {16'd0, refresh_count}, 32'd3);
    cas_n = 1'b0;
    settle(SETTLE);
    chk("cas_fall_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});
    ras_n = 1'b0;
    settle(SETTLE);
    chk("cbr_state", {29'd0, state_dbg}, {29'd0, S_CBR});
    ras_n = 1'b1;
    settle(SETTLE);
    cas_n = 1'b1;
    settle(SETTLE);
    chk("refresh_cbr", {16'd0, refresh_count}, 32'd4);
    dram_read(18'd255, 16'hAB55);
    dram_read(18'd256, 16'h6666);

    // Read-modify-write at 256.
    ma = 10'd1; ras_n = 1'b0;
    settle(SETTLE);
    ma = 10'd0; oe_n = 1'b0; cas_n = 1'b0;
    settle(SETTLE);
    chk("rmw_read", {16'd0, dq_out}, 32'h6666);
    chk("rmw_oe_high", {31'd0, dq_oe}, 32'd1);
    dq_in = 16'h1234; uwe_n = 1'b0; lwe_n = 1'b0;
    settle(SETTLE);
    chk("rmw_oe_drop", {31'd0, dq_oe}, 32'd0);
    chk("rmw_state", {29'd0, state_dbg}, {29'd0, S_COL_WR});
    cas_n = 1'b1;
    settle(SETTLE);
    ras_n = 1'b1; uwe_n = 1'b1; lwe_n = 1'b1; oe_n = 1'b1;
    settle(SETTLE);
    dram_read(18'd256, 16'h1234);
    dram_read(18'd255, 16'hAB55);
    chk("refresh_hold", {16'd0, refresh_count}, 32'd4);

    // Reset in the middle of a read.
    ma = 10'd1; ras_n = 1'b0;
    settle(SETTLE);
    ma = 10'd0; oe_n = 1'b0; cas_n = 1'b0;
    settle(SETTLE);
    chk("pre_reset_oe", {31'd0, dq_oe}, 32'd1);
    reset = 1'b1;
    settle(1);
    chk("mid_reset_oe", {31'd0, dq_oe}, 32'd0);
    chk("mid_reset_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    chk("mid_reset_refresh", {16'd0, refresh_count}, 32'd0);
    ras_n = 1'b1; cas_n = 1'b1; oe_n = 1'b1;
    settle(3);
    reset = 1'b0;
    settle(SETTLE);
    chk("post_reset_row", {31'd0, row_active}, 32'd0);
    dram_read(18'd256, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
